axi_slave_memory_pipelined: RTL

//   Parametrised behavioural memory model for bus testbenches: an AXI slave adapter's backing store.

---
 rtl/axi_slave_memory_pipelined_if.sv | 55 +++++
 rtl/axi_slave_memory_pipelined.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/axi_slave_memory_pipelined_if.sv
// ---------------------------------------------------------------------------
// axi_slave_memory_pipelined_if
//   Request/response bundle between a requester and the pipelined memory
//   model. The suffixes are from the memory's point of view: _i is driven by
//   the master, _o is driven by the memory (slave).
//
//   load_address_i   byte address of a load
//   load_i           load request, one transaction per high cycle
//   load_data_o      load data, valid while load_done_o is high, else 0
//   load_done_o      one-cycle response pulse per accepted load
//   load_error_o     load address was out of range
//   store_address_i  byte address of a store
//   store_data_i     store data, byte lanes [BYTES-1:0][7:0]
//   store_strobe_i   byte-lane write enables
//   store_i          store request, one transaction per high cycle
//   store_done_o     one-cycle response pulse per accepted store
//   store_error_o    store address was out of range
//   load_count_o     load responses issued since reset
//   store_count_o    store responses issued since reset
// ---------------------------------------------------------------------------
interface axi_slave_memory_pipelined_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [31:0]           load_address_i;
  logic                  load_i;
  logic [DATA_WIDTH-1:0] load_data_o;
  logic                  load_done_o;
  logic                  load_error_o;
  logic [31:0]           store_address_i;
  logic [DATA_WIDTH-1:0] store_data_i;
  logic [BYTES-1:0]      store_strobe_i;
  logic                  store_i;
  logic                  store_done_o;
  logic                  store_error_o;
  logic [31:0]           load_count_o;
  logic [31:0]           store_count_o;

  modport slave (
    input  load_address_i, load_i,
    input  store_address_i, store_data_i, store_strobe_i, store_i,
    output load_data_o, load_done_o, load_error_o,
    output store_done_o, store_error_o,
    output load_count_o, store_count_o
  );

  modport master (
    output load_address_i, load_i,
    output store_address_i, store_data_i, store_strobe_i, store_i,
    input  load_data_o, load_done_o, load_error_o,
    input  store_done_o, store_error_o,
    input  load_count_o, store_count_o
  );
endinterface

// File: rtl/axi_slave_memory_pipelined.sv
// ---------------------------------------------------------------------------
// axi_slave_memory_pipelined
//   Behavioural backing store for an AXI slave adapter. Independent load and
//   store channels, each accepting one request per cycle with no backpressure.
//   Responses travel fixed-latency shift pipelines so back-to-back requests
//   give back-to-back done pulses in order. Out-of-range addresses respond
//   with an error and never touch the array.
//
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous active-low reset; flushes the response pipelines and
//            counters, leaves the memory contents alone
//   bus      axi_slave_memory_pipelined_if.slave, load/store request and
//            response signals plus the completed-transaction counters
// ---------------------------------------------------------------------------
module axi_slave_memory_pipelined #(
  parameter int MEMORY_SIZE   = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LOAD_LATENCY  = 1,
  parameter int STORE_LATENCY = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  axi_slave_memory_pipelined_if.slave  bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam int OFF_W = $clog2(BYTES);
  // 33 bits so that a 4 GiB memory still has a representable limit.
  localparam logic [32:0] ADDR_LIMIT = 33'(MEMORY_SIZE * BYTES);

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic             loadInRange;
  logic             storeInRange;
  logic [IDX_W-1:0] loadIndex;
  logic [IDX_W-1:0] storeIndex;
  logic             storeWrite;

  assign loadInRange  = {1'b0, bus.load_address_i}  < ADDR_LIMIT;
  assign storeInRange = {1'b0, bus.store_address_i} < ADDR_LIMIT;
  assign loadIndex    = bus.load_address_i[IDX_W+OFF_W-1:OFF_W];
  assign storeIndex   = bus.store_address_i[IDX_W+OFF_W-1:OFF_W];
  assign storeWrite   = bus.store_i && storeInRange;

  // ---------------------------------------------------------------------
  // Memory array. Each word is its own register so it can carry a
  // power-up value (word[i] = i) without an initial block; none of them
  // sees the reset, so stores survive a reset pulse. Reads elsewhere use
  // the pre-edge contents, which gives same-edge loads the old value.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] memWords [MEMORY_SIZE];

  for (genvar g = 0; g < MEMORY_SIZE; g++) begin : gWord
    logic [DATA_WIDTH-1:0] word_q = DATA_WIDTH'(g);

    always_ff @(posedge clk_i) begin
      if (storeWrite && (storeIndex == IDX_W'(g))) begin
        for (int b = 0; b < BYTES; b++) begin
          if (bus.store_strobe_i[b]) begin
            word_q[8*b +: 8] <= bus.store_data_i[8*b +: 8];
          end
        end
      end
    end

    assign memWords[g] = word_q;
  end

  // ---------------------------------------------------------------------
  // Stage-0 inputs for both response pipelines. Load data is forced to 0
  // on idle or error so the output needs no extra gating.
  // ---------------------------------------------------------------------
  logic                  loadValid_d;
  logic                  loadError_d;
  logic [DATA_WIDTH-1:0] loadData_d;
  logic                  storeValid_d;
  logic                  storeError_d;

  always_comb begin
    loadValid_d  = bus.load_i;
    loadError_d  = bus.load_i && !loadInRange;
    loadData_d   = '0;
    storeValid_d = bus.store_i;
    storeError_d = bus.store_i && !storeInRange;
    if (bus.load_i && loadInRange) begin
      loadData_d = memWords[loadIndex];
    end
  end

  // ---------------------------------------------------------------------
  // Load response pipeline, LOAD_LATENCY stages; the last stage drives
  // the outputs.
  // ---------------------------------------------------------------------
  logic [LOAD_LATENCY-1:0] loadValid_q;
  logic [LOAD_LATENCY-1:0] loadError_q;
  logic [DATA_WIDTH-1:0]   loadData_q [LOAD_LATENCY];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      loadValid_q <= '0;
      loadError_q <= '0;
      for (int s = 0; s < LOAD_LATENCY; s++) begin
        loadData_q[s] <= '0;
      end
    end else begin
      loadValid_q[0] <= loadValid_d;
      loadError_q[0] <= loadError_d;
      loadData_q[0]  <= loadData_d;
      for (int s = 1; s < LOAD_LATENCY; s++) begin
        loadValid_q[s] <= loadValid_q[s-1];
        loadError_q[s] <= loadError_q[s-1];
        loadData_q[s]  <= loadData_q[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Store response pipeline. The write already happened at accept time;
  // only the response is delayed.
  // ---------------------------------------------------------------------
  logic [STORE_LATENCY-1:0] storeValid_q;
  logic [STORE_LATENCY-1:0] storeError_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      storeValid_q <= '0;
      storeError_q <= '0;
    end else begin
      storeValid_q[0] <= storeValid_d;
      storeError_q[0] <= storeError_d;
      for (int s = 1; s < STORE_LATENCY; s++) begin
        storeValid_q[s] <= storeValid_q[s-1];
        storeError_q[s] <= storeError_q[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Completed-transaction counters, stepped on each done cycle and left
  // to wrap naturally.
  // ---------------------------------------------------------------------
  logic [31:0] loadCount_q;
  logic [31:0] loadCount_d;
  logic [31:0] storeCount_q;
  logic [31:0] storeCount_d;

  always_comb begin
    loadCount_d  = loadCount_q  + 32'(loadValid_q[LOAD_LATENCY-1]);
    storeCount_d = storeCount_q + 32'(storeValid_q[STORE_LATENCY-1]);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      loadCount_q  <= '0;
      storeCount_q <= '0;
    end else begin
      loadCount_q  <= loadCount_d;
      storeCount_q <= storeCount_d;
    end
  end

  assign bus.load_done_o   = loadValid_q[LOAD_LATENCY-1];
  assign bus.load_error_o  = loadError_q[LOAD_LATENCY-1];
  assign bus.load_data_o   = loadData_q[LOAD_LATENCY-1];
  assign bus.store_done_o  = storeValid_q[STORE_LATENCY-1];
  assign bus.store_error_o = storeError_q[STORE_LATENCY-1];
  assign bus.load_count_o  = loadCount_q;
  assign bus.store_count_o = storeCount_q;

endmodule
